tvram_dma_sched: RTL and testbench
==================================

Name: tvram_dma_sched

Overview:
- Schedules the two CPU-issued text/palette DMA commands onto the shared 68k bus.
- Latches command pulses, arbitrates between them, and runs the BUSREQ/BUSACK handshake with the CPU.
- Issues one start pulse per transfer to the copy engine, then waits for its completion.
- Sits between the CPU DMA-command decode and the text VRAM DMA engine. Also enforces that the text-ROM unpack transfer runs once per reset.

Parameters:
- ACK_TIMEOUT, 1024: CLK96 cycles to wait for BUSACK after raising BUSREQ before abandoning the request.
- TW, 11: width of the ack-timeout counter; must satisfy 2^TW > ACK_TIMEOUT.

Ports:
- CLK96  in  1  single clock; all logic on its rising edge.
- RESET96  in  1  asynchronous, active-high reset.
- TEXTDATA_REQ  in  1  one-cycle pulse: CPU wrote the text-data (ROM unpack) DMA command.
- PALTEXT_REQ  in  1  one-cycle pulse: CPU wrote the palette/text DMA command.
- VBLANK  in  1  vertical blank level from video timing.
- BUSACK  in  1  CPU bus grant level.
- DMA_DONE  in  1  one-cycle pulse from the copy engine: transfer finished.
- BUSREQ  out  1  bus request to the CPU, registered.
- DMA_GO  out  1  one-cycle start pulse to the copy engine.
- DMA_SEL  out  1  transfer selected: 1 = text data, 0 = palette/text; stable from DMA_GO until return to IDLE.
- BUSY  out  1  high when state is not IDLE or any request is pending.
- TEXTROM_LOCKED  out  1  set after the first completed text-data transfer.
- ACK_TIMEOUT_ERR  out  1  sticky flag: a BUSACK timeout occurred.
- XFER_COUNT  out  8  completed-transfer counter; wraps 255 -> 0.

Behaviour:
- Reset (asynchronous, any state including mid-transfer): state=IDLE. All outputs 0. Both pending bits cleared. Timeout counter cleared. TEXTROM_LOCKED, ACK_TIMEOUT_ERR and XFER_COUNT cleared.
- Pending bits:
  - pend_txt is set by TEXTDATA_REQ only while TEXTROM_LOCKED=0; it is ignored when locked.
  - pend_pal is set by PALTEXT_REQ.
  - Repeated pulses while a bit is pending coalesce into one request.
  - A set arriving in the same cycle as the clear of the same bit wins (the bit stays 1).
- States: IDLE, REQ, GO, RUN, REL.
- IDLE:
  - If pend_txt: DMA_SEL<=1, go to REQ.
  - Else if pend_pal: DMA_SEL<=0, go to REQ.
  - Text data has fixed priority. BUSREQ<=1 on the transition, so it is high one cycle after the pending bit is seen.
- REQ:
  - Timeout counter increments each cycle.
  - If BUSACK=1: go to GO and clear the counter.
  - Else if counter==ACK_TIMEOUT-1: ACK_TIMEOUT_ERR<=1, BUSREQ<=0, go to REL. The pending bit is kept, so the request retries later.
  - If both conditions are true in the same cycle, the ack wins.
- GO: DMA_GO=1 for exactly this one cycle. Clear the selected pending bit. Go to RUN.
- RUN:
  - BUSREQ held high; wait indefinitely for DMA_DONE.
  - On DMA_DONE: BUSREQ<=0 and XFER_COUNT increments.
  - If DMA_SEL=1, also TEXTROM_LOCKED<=1.
  - Go to REL.
  - DMA_DONE in any other state is ignored.
- REL: wait for BUSACK=0, then go to IDLE. BUSREQ is never re-raised before BUSACK has dropped.
- Latency: request pulse at cycle n gives BUSREQ high at n+2. BUSACK seen at cycle m gives DMA_GO at m+1.
- A request that arrives during RUN stays pending. It is served after REL -> IDLE, no earlier than 2 cycles after BUSACK falls.
- A BUSACK glitch low during RUN is ignored; the handshake is owned by this block until DMA_DONE.

Optional Feature:
- Macro: TVRAM_DMA_VBLANK_GATE_EN.
- Defined:
  - In IDLE, pend_pal may start only while VBLANK=1. pend_txt is not gated.
  - Once REQ is entered, later VBLANK changes have no effect.
- Not defined: VBLANK is ignored and pend_pal starts as soon as IDLE sees it.

Test Plan:
- Reset, PALTEXT_REQ pulse at cycle 10, BUSACK raised at 15, DMA_DONE at 40, BUSACK dropped at 43 -> BUSREQ high at 12, DMA_GO at 16 with DMA_SEL=0, BUSREQ low at 41, IDLE at 44, XFER_COUNT=1.
- TEXTDATA_REQ and PALTEXT_REQ pulsed in the same cycle -> text transfer first (DMA_SEL=1), then palette (DMA_SEL=0), two DMA_GO pulses, TEXTROM_LOCKED=1 after the first DMA_DONE.
- After lock, TEXTDATA_REQ pulse -> no BUSREQ, BUSY stays 0.
- ACK_TIMEOUT=16, BUSACK held 0 -> BUSREQ drops 16 cycles after rising, ACK_TIMEOUT_ERR=1, state re-enters REQ (pend_pal kept); BUSACK then raised -> transfer completes, ERR stays 1.
- RESET96 asserted during RUN -> BUSREQ=0, DMA_SEL=0, pending bits and TEXTROM_LOCKED=0 immediately, asynchronous to the clock edge.
- With TVRAM_DMA_VBLANK_GATE_EN, PALTEXT_REQ at VBLANK=0 -> BUSREQ stays 0 until VBLANK rises, then high 1 cycle later.

Source files
------------

// File: rtl/tvram_dma_sched.sv
// Text/palette DMA scheduler: latches CPU DMA commands, arbitrates them, and runs the 68k BUSREQ/BUSACK handshake.
// Build option: define TVRAM_DMA_VBLANK_GATE_EN to allow palette transfers to start only during VBLANK.
module tvram_dma_sched #(
    parameter int ACK_TIMEOUT = 1024,
    parameter int TW          = 11
) (
    input  logic       CLK96,
    input  logic       RESET96,
    input  logic       TEXTDATA_REQ,
    input  logic       PALTEXT_REQ,
    input  logic       VBLANK,
    input  logic       BUSACK,
    input  logic       DMA_DONE,
    output logic       BUSREQ,
    output logic       DMA_GO,
    output logic       DMA_SEL,
    output logic       BUSY,
    output logic       TEXTROM_LOCKED,
    output logic       ACK_TIMEOUT_ERR,
    output logic [7:0] XFER_COUNT
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_GO, S_RUN, S_REL} state_t;

    state_t        state, state_n;
    logic          pend_txt, pend_pal;
    logic          clr_txt, clr_pal;
    logic          pal_start_ok;
    logic [TW-1:0] ack_cnt, ack_cnt_n;
    logic          busreq_n, sel_n, locked_n, err_n;
    logic [7:0]    xfer_n;

`ifdef TVRAM_DMA_VBLANK_GATE_EN
    assign pal_start_ok = VBLANK;
`else
    logic vblank_unused;
    assign vblank_unused = VBLANK;
    assign pal_start_ok  = 1'b1;
`endif

    assign DMA_GO = (state == S_GO);
    assign BUSY   = (state != S_IDLE) | pend_txt | pend_pal;

    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            pend_txt <= 1'b0;
            pend_pal <= 1'b0;
        end else begin
            // A new command in the clearing cycle keeps the bit set
            pend_txt <= (TEXTDATA_REQ & ~TEXTROM_LOCKED) | (pend_txt & ~clr_txt);
            pend_pal <= PALTEXT_REQ | (pend_pal & ~clr_pal);
        end
    end

    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            state           <= S_IDLE;
            ack_cnt         <= '0;
            BUSREQ          <= 1'b0;
            DMA_SEL         <= 1'b0;
            TEXTROM_LOCKED  <= 1'b0;
            ACK_TIMEOUT_ERR <= 1'b0;
            XFER_COUNT      <= '0;
        end else begin
            state           <= state_n;
            ack_cnt         <= ack_cnt_n;
            BUSREQ          <= busreq_n;
            DMA_SEL         <= sel_n;
            TEXTROM_LOCKED  <= locked_n;
            ACK_TIMEOUT_ERR <= err_n;
            XFER_COUNT      <= xfer_n;
        end
    end

    always_comb begin
        state_n   = state;
        ack_cnt_n = ack_cnt;
        busreq_n  = BUSREQ;
        sel_n     = DMA_SEL;
        locked_n  = TEXTROM_LOCKED;
        err_n     = ACK_TIMEOUT_ERR;
        xfer_n    = XFER_COUNT;
        clr_txt   = 1'b0;
        clr_pal   = 1'b0;
        case (state)
            S_IDLE: begin
                ack_cnt_n = '0;
                if (pend_txt) begin
                    sel_n    = 1'b1;
                    busreq_n = 1'b1;
                    state_n  = S_REQ;
                end else if (pend_pal && pal_start_ok) begin
                    sel_n    = 1'b0;
                    busreq_n = 1'b1;
                    state_n  = S_REQ;
                end
            end
            S_REQ: begin
                // Grant takes precedence over a timeout in the same cycle
                if (BUSACK) begin
                    ack_cnt_n = '0;
                    state_n   = S_GO;
                end else if (ack_cnt == TW'(ACK_TIMEOUT - 1)) begin
                    ack_cnt_n = '0;
                    err_n     = 1'b1;
                    busreq_n  = 1'b0;
                    state_n   = S_REL;
                end else begin
                    ack_cnt_n = ack_cnt + TW'(1);
                end
            end
            S_GO: begin
                clr_txt = DMA_SEL;
                clr_pal = ~DMA_SEL;
                state_n = S_RUN;
            end
            S_RUN: begin
                if (DMA_DONE) begin
                    busreq_n = 1'b0;
                    xfer_n   = XFER_COUNT + 8'd1;
                    if (DMA_SEL) locked_n = 1'b1;
                    state_n  = S_REL;
                end
            end
            S_REL: begin
                if (!BUSACK) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_tvram_dma_sched.sv
// Self-checking bench for tvram_dma_sched: directed scenarios with literal expectations,
// then randomized CPU/engine traffic compared every cycle against a transaction-level model.
module tb_tvram_dma_sched;

    localparam int ACK_TO = 16;
    localparam int TWID   = 5;

    logic       CLK96 = 1'b0;
    logic       RESET96 = 1'b1;
    logic       TEXTDATA_REQ = 1'b0;
    logic       PALTEXT_REQ = 1'b0;
    logic       VBLANK = 1'b1;
    logic       BUSACK = 1'b0;
    logic       DMA_DONE = 1'b0;
    logic       BUSREQ, DMA_GO, DMA_SEL, BUSY, TEXTROM_LOCKED, ACK_TIMEOUT_ERR;
    logic [7:0] XFER_COUNT;

    tvram_dma_sched #(.ACK_TIMEOUT(ACK_TO), .TW(TWID)) dut (
        .CLK96(CLK96), .RESET96(RESET96), .TEXTDATA_REQ(TEXTDATA_REQ), .PALTEXT_REQ(PALTEXT_REQ),
        .VBLANK(VBLANK), .BUSACK(BUSACK), .DMA_DONE(DMA_DONE), .BUSREQ(BUSREQ), .DMA_GO(DMA_GO),
        .DMA_SEL(DMA_SEL), .BUSY(BUSY), .TEXTROM_LOCKED(TEXTROM_LOCKED),
        .ACK_TIMEOUT_ERR(ACK_TIMEOUT_ERR), .XFER_COUNT(XFER_COUNT)
    );

    always #5 CLK96 = ~CLK96;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit chk_en = 0;

    // Transaction-level model of the scheduler
    typedef enum int {M_IDLE, M_ASK, M_START, M_COPY, M_RELEASE} mphase_t;
    mphase_t m_phase;
    bit      m_pend_txt, m_pend_pal, m_busreq, m_sel, m_lock, m_err;
    int      m_wait, m_count;

    // Environment (CPU grant + copy engine) state
    int ack_wait, done_wait;
    bit eng_busy, engine_hold, no_ack;
    bit go_sels[$];

    function automatic void chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s (cycle %0d): DUT=%0d expected=%0d", name, cyc, act, req);
        end
    endfunction

    function automatic void model_reset();
        m_phase = M_IDLE;
        m_pend_txt = 0; m_pend_pal = 0; m_busreq = 0; m_sel = 0;
        m_lock = 0; m_err = 0; m_wait = 0; m_count = 0;
    endfunction

    function automatic void model_step();
        bit set_txt, set_pal, pal_ok;
        set_txt = TEXTDATA_REQ && !m_lock;
        set_pal = PALTEXT_REQ;
`ifdef TVRAM_DMA_VBLANK_GATE_EN
        pal_ok = VBLANK;
`else
        pal_ok = 1;
`endif
        case (m_phase)
            M_IDLE: begin
                if (m_pend_txt || (m_pend_pal && pal_ok)) begin
                    m_sel = m_pend_txt;
                    m_busreq = 1;
                    m_wait = 0;
                    m_phase = M_ASK;
                end
            end
            M_ASK: begin
                if (BUSACK) m_phase = M_START;
                else if (m_wait == ACK_TO - 1) begin
                    m_err = 1; m_busreq = 0; m_phase = M_RELEASE;
                end else m_wait++;
            end
            M_START: begin
                if (m_sel) m_pend_txt = 0; else m_pend_pal = 0;
                m_phase = M_COPY;
            end
            M_COPY: begin
                if (DMA_DONE) begin
                    m_busreq = 0;
                    m_count = (m_count + 1) % 256;
                    if (m_sel) m_lock = 1;
                    m_phase = M_RELEASE;
                end
            end
            default: if (!BUSACK) m_phase = M_IDLE;
        endcase
        if (set_txt) m_pend_txt = 1;
        if (set_pal) m_pend_pal = 1;
    endfunction

    always @(negedge CLK96) begin
        if (chk_en) begin
            chk("busreq", BUSREQ, m_busreq);
            chk("dma_go", DMA_GO, m_phase == M_START);
            chk("dma_sel", DMA_SEL, m_sel);
            chk("busy", BUSY, m_phase != M_IDLE || m_pend_txt || m_pend_pal);
            chk("textrom_locked", TEXTROM_LOCKED, m_lock);
            chk("ack_timeout_err", ACK_TIMEOUT_ERR, m_err);
            chk("xfer_count", XFER_COUNT, m_count);
        end
    end

    function automatic void env_reset();
        ack_wait = 1; done_wait = 0; eng_busy = 0; engine_hold = 0; no_ack = 0;
    endfunction

    task automatic step();
        @(posedge CLK96);
        cyc++;
        model_step();
        @(negedge CLK96);
        TEXTDATA_REQ = 0; PALTEXT_REQ = 0; DMA_DONE = 0;
        if (DMA_GO) go_sels.push_back(DMA_SEL);
    endtask

    task automatic drive_env(input bit rnd);
        if (!BUSREQ) begin
            ack_wait = rnd ? (($urandom_range(0, 7) == 0) ? 40 : int'($urandom_range(0, 3))) : 1;
            if (BUSACK && (!rnd || $urandom_range(0, 1) == 0)) BUSACK = 0;
        end else if (!BUSACK) begin
            if (!no_ack) begin
                if (ack_wait == 0) BUSACK = 1; else ack_wait--;
            end
        end else if (rnd && m_phase == M_COPY && $urandom_range(0, 15) == 0) begin
            BUSACK = 0;
        end
        DMA_DONE = 0;
        if (DMA_GO) begin
            eng_busy = 1;
            done_wait = rnd ? int'($urandom_range(1, 8)) : 3;
        end else if (eng_busy) begin
            if (!engine_hold) begin
                if (done_wait <= 1) begin DMA_DONE = 1; eng_busy = 0; end
                else done_wait--;
            end
        end else if (rnd && $urandom_range(0, 31) == 0) begin
            DMA_DONE = 1;
        end
        if (rnd) begin
            TEXTDATA_REQ = ($urandom_range(0, 19) == 0);
            PALTEXT_REQ  = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 15) == 0) VBLANK = ~VBLANK;
        end
    endtask

    task automatic do_reset();
        #2 RESET96 = 1;
        model_reset();
        env_reset();
        @(negedge CLK96);
        @(negedge CLK96);
        RESET96 = 0;
    endtask

    task automatic reset_in_run(input bit txt);
        int n;
        n = 0;
        engine_hold = 1;
        if (txt) TEXTDATA_REQ = 1; else PALTEXT_REQ = 1;
        while (m_phase != M_COPY && n < 40) begin
            drive_env(0);
            step();
            n++;
        end
        drive_env(0);
        step();
        chk("rir_busreq_before", BUSREQ, 1);
        chk("rir_sel_before", DMA_SEL, txt);
        #2 RESET96 = 1;
        model_reset();
        #1;
        chk("rir_busreq_async", BUSREQ, 0);
        chk("rir_sel_async", DMA_SEL, 0);
        chk("rir_busy_async", BUSY, 0);
        chk("rir_locked_async", TEXTROM_LOCKED, 0);
        chk("rir_go_async", DMA_GO, 0);
        chk("rir_count_async", XFER_COUNT, 0);
        env_reset();
        @(negedge CLK96);
        @(negedge CLK96);
        RESET96 = 0;
    endtask

    initial begin
        int t, s0, s1;
        model_reset();
        env_reset();
        repeat (3) @(negedge CLK96);
        RESET96 = 0;
        cyc = 0;
        chk("rst_busreq", BUSREQ, 0);
        chk("rst_go", DMA_GO, 0);
        chk("rst_sel", DMA_SEL, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_locked", TEXTROM_LOCKED, 0);
        chk("rst_err", ACK_TIMEOUT_ERR, 0);
        chk("rst_count", XFER_COUNT, 0);
        chk_en = 1;

        // Single palette transfer with a scripted handshake
        for (int c = 0; c < 50; c++) begin
            case (cyc)
                11: chk("s1_busreq_c11", BUSREQ, 0);
                12: chk("s1_busreq_c12", BUSREQ, 1);
                15: chk("s1_go_c15", DMA_GO, 0);
                16: begin chk("s1_go_c16", DMA_GO, 1); chk("s1_sel_c16", DMA_SEL, 0); end
                40: chk("s1_busreq_c40", BUSREQ, 1);
                41: chk("s1_busreq_c41", BUSREQ, 0);
                43: chk("s1_busy_c43", BUSY, 1);
                44: begin chk("s1_busy_c44", BUSY, 0); chk("s1_count_c44", XFER_COUNT, 1); end
                default: ;
            endcase
            PALTEXT_REQ = (cyc == 10);
            DMA_DONE = (cyc == 40);
            if (cyc == 15) BUSACK = 1;
            if (cyc == 43) BUSACK = 0;
            step();
        end

        // Simultaneous commands: text first, then palette
        go_sels.delete();
        TEXTDATA_REQ = 1;
        PALTEXT_REQ = 1;
        repeat (60) begin drive_env(0); step(); end
        s0 = (go_sels.size() > 0) ? int'(go_sels[0]) : 9;
        s1 = (go_sels.size() > 1) ? int'(go_sels[1]) : 9;
        chk("both_go_count", go_sels.size(), 2);
        chk("both_first_sel", s0, 1);
        chk("both_second_sel", s1, 0);
        chk("both_locked", TEXTROM_LOCKED, 1);
        chk("both_count", XFER_COUNT, 3);

        // Text command after lock is ignored
        TEXTDATA_REQ = 1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin chk("lock_busy", BUSY, 0); chk("lock_busreq", BUSREQ, 0); end
            drive_env(0);
            step();
        end

        // Ack timeout, retry, then a granted transfer
        no_ack = 1;
        t = cyc;
        PALTEXT_REQ = 1;
        for (int k = 0; k < 26; k++) begin
            if (k == 17) begin chk("to_busreq_k17", BUSREQ, 1); chk("to_err_k17", ACK_TIMEOUT_ERR, 0); end
            if (k == 18) begin chk("to_busreq_k18", BUSREQ, 0); chk("to_err_k18", ACK_TIMEOUT_ERR, 1); end
            if (k == 20) chk("to_retry_busreq", BUSREQ, 1);
            drive_env(0);
            step();
        end
        no_ack = 0;
        repeat (30) begin drive_env(0); step(); end
        chk("to_count", XFER_COUNT, 4);
        chk("to_err_sticky", ACK_TIMEOUT_ERR, 1);
        chk("to_busy", BUSY, 0);

        // Palette start relative to VBLANK
        VBLANK = 0;
        PALTEXT_REQ = 1;
        for (int k = 0; k < 10; k++) begin
`ifdef TVRAM_DMA_VBLANK_GATE_EN
            if (k >= 2 && k <= 6) chk("gate_hold", BUSREQ, 0);
            if (k == 7) chk("gate_release", BUSREQ, 1);
`else
            if (k == 1) chk("nogate_k1", BUSREQ, 0);
            if (k == 2) chk("nogate_k2", BUSREQ, 1);
`endif
            if (k == 6) VBLANK = 1;
            drive_env(0);
            step();
        end
        repeat (30) begin drive_env(0); step(); end

        // Asynchronous reset while a transfer is running
        reset_in_run(0);
        reset_in_run(1);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 600 == 599) do_reset();
            drive_env(1);
            step();
        end

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
